// File: rtl/alu_vector_sequencer.sv
// BIST initiator for the 4-bit ALU: fetches vectors, drives S/A/B, samples R
// after a settle delay, counts mismatches and reports each one with a pulse.
module alu_vector_sequencer #(
    parameter int ADDR_W = 8,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              vec_rd_en,
    output logic [ADDR_W-1:0] vec_addr,
    input  logic [20:0]       vec_data,
    output logic [2:0]        alu_s,
    output logic [3:0]        alu_a,
    output logic [3:0]        alu_b,
    input  logic [7:0]        alu_r,
    output logic [ADDR_W:0]   vec_count,
    output logic [ERR_W-1:0]  err_count,
    output logic              fail_valid,
    output logic [20:0]       fail_vector,
    output logic [7:0]        fail_actual
);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, WAIT, CHECK, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;
    // WAIT exits when the down-counter reaches zero, so it is loaded with SETTLE-1.
    localparam logic [3:0]        WAIT_INIT = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
    localparam state_t            AFTER_LOAD = (SETTLE > 0) ? WAIT : CHECK;

    state_t      state_reg;
    logic [3:0]  wait_reg;
    logic [7:0]  exp_reg;
    logic [20:0] vec_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            vec_rd_en   <= 1'b0;
            vec_addr    <= '0;
            alu_s       <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            vec_count   <= '0;
            err_count   <= '0;
            fail_valid  <= 1'b0;
            fail_vector <= '0;
            fail_actual <= '0;
            wait_reg    <= '0;
            exp_reg     <= '0;
            vec_reg     <= '0;
        end else begin
            vec_rd_en  <= 1'b0;
            fail_valid <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        vec_count <= '0;
                        err_count <= '0;
                        vec_addr  <= '0;
                        done      <= 1'b0;
                        busy      <= 1'b1;
                        vec_rd_en <= 1'b1;
                        state_reg <= FETCH;
                    end
                end
                FETCH: state_reg <= LOAD;
                LOAD: begin
                    // An all-zero word ends the run without being counted.
                    if (vec_data == 21'd0) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        alu_s     <= vec_data[20:18];
                        alu_a     <= vec_data[17:14];
                        alu_b     <= vec_data[13:10];
                        exp_reg   <= vec_data[7:0];
                        vec_reg   <= vec_data;
                        wait_reg  <= WAIT_INIT;
                        state_reg <= AFTER_LOAD;
                    end
                end
                WAIT: begin
                    if (wait_reg == 4'd0) begin
                        state_reg <= CHECK;
                    end else begin
                        wait_reg <= wait_reg - 1'b1;
                    end
                end
                CHECK: begin
                    vec_count <= vec_count + 1'b1;
                    if (alu_r != exp_reg) begin
                        if (err_count != ERR_MAX) begin
                            err_count <= err_count + 1'b1;
                        end
                        fail_valid  <= 1'b1;
                        fail_vector <= vec_reg;
                        fail_actual <= alu_r;
                    end
                    // The last address ends the run instead of wrapping to 0.
                    if (vec_addr == LAST_ADDR) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        vec_addr  <= vec_addr + 1'b1;
                        vec_rd_en <= 1'b1;
                        state_reg <= FETCH;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
